approx_mul_seq: RTL

Parametrised, sequential shift-add unsigned multiplier with a run-time selectable approximate mode. Approximate mode drops the low partial-product columns (`TRUNC`). Every result is also computed exactly, and an error monitor flags and counts results whose error exceeds `ET`. It generalises the team's fixed-width combinational approximate multipliers into a handshaked datapath block. Error statistics are observable in silicon.

---
 rtl/approx_mul_pkg.sv | 22 ++
 rtl/approx_err_monitor.sv | 48 ++++
 rtl/approx_mul_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the sequential approximate multiplier.
//   apx_state_t : controller states (idle, accumulating, result held)
//   apx_mask    : column mask applied to every approximate partial product
package approx_mul_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} apx_state_t;

  // Widest product the mask helper supports; callers slice to their own 2W.
  localparam int unsigned MaxProdW = 64;

  // Ones in columns [trunc, 2w), zeros in the truncated low columns and above the product.
  function automatic logic [MaxProdW-1:0] apx_mask(input int unsigned w,
                                                    input int unsigned trunc);
    logic [MaxProdW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxProdW; i++) begin
      m[i] = (i >= trunc) && (i < 2 * w);
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_err_monitor.sv
// Error statistics for consumed results.
//   clk, rst_n : clock, async active-low reset
//   hs         : output handshake strobe (result consumed this cycle)
//   mode       : result was approximate
//   err        : exact minus approximate for the consumed result
//   err_flag   : result exceeded the error threshold
//   clr_stats  : synchronous clear, wins over a coincident update
//   err_cnt    : saturating count of consumed flagged results
//   max_err    : largest err among consumed approximate results
module approx_err_monitor #(
  parameter int unsigned PW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic             mode,
  input  logic [PW-1:0]    err,
  input  logic             err_flag,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] err_cnt,
  output logic [PW-1:0]    max_err
);

  logic [CNT_W-1:0] err_cnt_q;
  logic [PW-1:0]    max_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      max_err_q <= '0;
    end else if (clr_stats) begin
      err_cnt_q <= '0;
      max_err_q <= '0;
    end else if (hs) begin
      if (err_flag && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      if (mode && (err > max_err_q)) begin
        max_err_q <= err;
      end
    end
  end

  assign err_cnt = err_cnt_q;
  assign max_err = max_err_q;

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-add unsigned multiplier with selectable approximate mode.
// Exact and truncated accumulators run side by side so every result carries its error.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake; a, b, mode captured on accept
//   out_valid/out_ready : result handshake; prod, err, err_flag held until consumed
//   clr_stats           : clear err_cnt and max_err
//   err_cnt, max_err    : running error statistics
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned TRUNC = 2,
  parameter int unsigned ET    = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod,
  output logic [2*W-1:0]   err,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2*W-1:0]   max_err,
  input  logic             clr_stats
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned StepW = (W > 1) ? $clog2(W) : 1;

  localparam logic [MaxProdW-1:0] MaskFull = apx_mask(W, TRUNC);
  localparam logic [PW-1:0]       Mask     = MaskFull[PW-1:0];
  localparam logic [PW-1:0]       EtV      = PW'(ET);
  localparam logic [StepW-1:0]    LastStep = StepW'(W - 1);

  apx_state_t       state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic             mode_q;
  logic [StepW-1:0] step_q;
  logic [PW-1:0]    acc_exact_q, acc_apx_q;
  logic             out_valid_q;
  logic [PW-1:0]    prod_q, err_q;
  logic             err_flag_q;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    err_now;
  logic             hs;

  assign pp      = b_q[step_q] ? (PW'(a_q) << step_q) : '0;
  assign err_now = acc_exact_q - acc_apx_q;
  assign hs      = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StBusy;
      StBusy:  if (step_q == LastStep) state_d = StDone;
      StDone:  if (hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      step_q      <= '0;
      acc_exact_q <= '0;
      acc_apx_q   <= '0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      err_q       <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q         <= a;
            b_q         <= b;
            mode_q      <= mode;
            step_q      <= '0;
            acc_exact_q <= '0;
            acc_apx_q   <= '0;
          end
        end
        StBusy: begin
          acc_exact_q <= acc_exact_q + pp;
          acc_apx_q   <= acc_apx_q + (pp & Mask);
          step_q      <= step_q + StepW'(1);
        end
        StDone: begin
          // First DONE cycle registers the result; it is then held until consumed.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            prod_q      <= mode_q ? acc_apx_q : acc_exact_q;
            err_q       <= err_now;
            err_flag_q  <= mode_q && (err_now > EtV);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            err_q       <= '0;
            err_flag_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign err       = err_q;
  assign err_flag  = err_flag_q;

  approx_err_monitor #(
    .PW    (PW),
    .CNT_W (CNT_W)
  ) u_err_monitor (
    .clk       (clk),
    .rst_n     (rst_n),
    .hs        (hs),
    .mode      (mode_q),
    .err       (err_q),
    .err_flag  (err_flag_q),
    .clr_stats (clr_stats),
    .err_cnt   (err_cnt),
    .max_err   (max_err)
  );

endmodule
